memory: RTL and testbench
=========================

Name: memory

Overview:
- Byte-addressable, little-endian data memory for the RISC-V core.
- Serves instruction-side or data-side loads and stores.
- Reads are combinational: a 32-bit word is assembled from 4 consecutive bytes starting at any byte address.
- Writes are synchronous and size-selectable (byte/halfword/word) to implement SB/SH/SW.

Parameters:
- DEPTH_BYTES, 4096, number of bytes stored; must be a power of two ≥ 4.
- ADDR_BITS, log2(DEPTH_BYTES), derived; internal index width.

Ports:
- clk  input  1  system clock; all writes on rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  32  byte address for both read and write.
- wr_data  input  32  store data; the low-order bytes are used for sub-word stores.
- wr_enable  input  1  1 = perform a store at the next rising clk edge.
- write_length  input  3  store size: 0 = byte, 1 = halfword, 2 = word, other values = no store.
- read_data  output  32  combinational load data at address.

Behaviour:
- Storage is an array of DEPTH_BYTES bytes.
- Effective index = address[ADDR_BITS-1:0]; upper address bits are ignored, so the address space aliases modulo DEPTH_BYTES.
- Read path:
  - read_data = {mem[a+3], mem[a+2], mem[a+1], mem[a]}, where a is the effective index. This is little-endian: the byte at the lowest address goes to bits [7:0].
  - Purely combinational, zero latency; follows address and memory contents within the same cycle.
  - Any alignment is allowed. Indices a+1..a+3 wrap modulo DEPTH_BYTES.
- Write path, on the rising edge of clk when wr_enable = 1 and reset = 0:
  - write_length 0: mem[a] ← wr_data[7:0].
  - write_length 1: mem[a] ← wr_data[7:0], mem[a+1] ← wr_data[15:8].
  - write_length 2: mem[a..a+3] ← wr_data[7:0], [15:8], [23:16], [31:24].
  - write_length 3..7: no bytes modified.
  - Unaligned stores are allowed; byte indices wrap modulo DEPTH_BYTES.
  - Bytes not selected by write_length keep their prior value.
- No write occurs on a falling edge, or while wr_enable = 0.
- Read during write, same cycle:
  - Before the rising edge, read_data shows the old contents.
  - After the edge, it shows the newly written bytes. There is no bypass of wr_data.
- Reset:
  - While reset = 1, any store is suppressed on that edge.
  - Memory contents are unchanged unless MEMORY_RESET_CLEAR_EN is defined.
  - read_data has no register and no reset value of its own; it always reflects the contents.
- Initial contents are all zero at time 0, via initialisation at elaboration.
- No wait states and no handshake; every access completes in one cycle.

Optional Feature:
- Macro: MEMORY_RESET_CLEAR_EN.
- Defined: a rising clk edge with reset = 1 sets every byte to 0x00. After that edge, read_data = 0x00000000 at all addresses. Reset takes priority over a simultaneous store.
- Undefined: reset only blocks stores, and contents are preserved across reset. This allows block-RAM inference.

Test Plan:
- Power-up, wr_enable=0, address=0, wr_data=0x89ABCDEF, write_length=1, one rising edge -> read_data ≠ 0x89ABCDEF (reads 0x00000000).
- Word store, address=5, wr_data=0x12345678, write_length=2, wr_enable=1 -> read_data ≠ 0x12345678 at the preceding falling edge; read_data = 0x12345678 at 1 time unit after the rising edge.
- Four byte stores on consecutive cycles, write_length=0:
  - (4, 0x12ABCDEF), (5, 0x34FBDEAD), (6, 0x56EDFABD), (7, 0x78ADEFAB).
  - Then address=4 -> read_data = 0xABBDADEF (little-endian).
- Halfword overwrite: word 0x1234ABCD at address 36 (write_length=2), then halfword 0x5678EFDA at 36 (write_length=1), then read 36 -> 0x1234EFDA.
- Invalid size and reset gating:
  - wr_enable=1, write_length=5, address=36 -> contents unchanged (0x1234EFDA).
  - reset=1 with a word store of 0xDEADBEEF at 36 -> store suppressed.
  - With MEMORY_RESET_CLEAR_EN defined, the same reset edge -> read 36 = 0x00000000.
- Wrap-around: word store 0xCAFEF00D at address DEPTH_BYTES-2 -> read at address DEPTH_BYTES-2 returns 0xCAFEF00D; read at address 0 returns low bytes 0xCAFE in [15:0].

Source files
------------

// File: rtl/memory.sv
// memory: byte-addressable little-endian RAM, async read, sized sync store; MEMORY_RESET_CLEAR_EN zeroes contents on reset.
module memory #(
  parameter int DEPTH_BYTES = 4096,
  parameter int ADDR_BITS = $clog2(DEPTH_BYTES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  input  logic        wr_enable,
  input  logic [2:0]  write_length,
  output logic [31:0] read_data
);
  logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};
  logic [ADDR_BITS-1:0] idx [4];
  logic [3:0] be;
  logic unused_hi;
  assign unused_hi = ^address[31:ADDR_BITS];
  for (genvar g = 0; g < 4; g++) begin : g_idx
    assign idx[g] = address[ADDR_BITS-1:0] + ADDR_BITS'(g);
  end
  assign be = write_length == 3'd0 ? 4'b0001 :
              write_length == 3'd1 ? 4'b0011 :
              write_length == 3'd2 ? 4'b1111 : 4'b0000;
  assign read_data = {mem[idx[3]], mem[idx[2]], mem[idx[1]], mem[idx[0]]};
  always_ff @(posedge clk) begin
`ifdef MEMORY_RESET_CLEAR_EN
    if (reset) begin
      for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= 8'h00;
    end else
`endif
    if (!reset && wr_enable) begin
      for (int i = 0; i < 4; i++) if (be[i]) mem[idx[i]] <= wr_data[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_memory.sv
// tb_memory: directed test-plan steps plus random stores/loads against a byte-array reference model.
module tb_memory;
  localparam int D = 4096;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wr_data = '0;
  logic        wr_enable = 1'b0;
  logic [2:0]  write_length = '0;
  logic [31:0] read_data;
  logic [7:0]  ref_mem [D];
  int tests = 0;
  int fails = 0;

  memory #(.DEPTH_BYTES(D)) dut (
    .clk(clk), .reset(reset), .address(address), .wr_data(wr_data),
    .wr_enable(wr_enable), .write_length(write_length), .read_data(read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_mem[(a + i) % D];
    return r;
  endfunction

  function automatic void model_edge(input logic [31:0] a, input logic [31:0] d,
                                     input logic we, input logic [2:0] len, input logic rs);
    int n;
    n = len == 0 ? 1 : len == 1 ? 2 : len == 2 ? 4 : 0;
    if (rs) begin
`ifdef MEMORY_RESET_CLEAR_EN
      for (int i = 0; i < D; i++) ref_mem[i] = 8'h00;
`endif
    end else if (we) begin
      for (int i = 0; i < n; i++) ref_mem[(a + i) % D] = d[8*i +: 8];
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] exp);
    tests++;
    assert (read_data === exp) else begin
      fails++;
      $error("FAIL %s: read_data=%h expected=%h", tag, read_data, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic we, input logic [2:0] len, input logic rs);
    @(negedge clk);
    address = a; wr_data = d; wr_enable = we; write_length = len; reset = rs;
    #1 check({tag, "_pre"}, model_read(a));
    @(posedge clk);
    model_edge(a, d, we, len, rs);
    #1 check({tag, "_post"}, model_read(a));
  endtask

  task automatic peek(input string tag, input logic [31:0] a);
    @(negedge clk);
    address = a; wr_enable = 1'b0; reset = 1'b0;
    #1 check(tag, model_read(a));
  endtask

  initial begin
    for (int i = 0; i < D; i++) ref_mem[i] = 8'h00;
    cyc("powerup", 32'd0, 32'h89ABCDEF, 1'b0, 3'd1, 1'b0);
    check("powerup_zero", 32'h0);
    cyc("word5", 32'd5, 32'h12345678, 1'b1, 3'd2, 1'b0);
    check("word5_val", 32'h12345678);
    cyc("b4", 32'd4, 32'h12ABCDEF, 1'b1, 3'd0, 1'b0);
    cyc("b5", 32'd5, 32'h34FBDEAD, 1'b1, 3'd0, 1'b0);
    cyc("b6", 32'd6, 32'h56EDFABD, 1'b1, 3'd0, 1'b0);
    cyc("b7", 32'd7, 32'h78ADEFAB, 1'b1, 3'd0, 1'b0);
    peek("bytes4", 32'd4);
    check("bytes4_val", 32'hABBDADEF);
    cyc("w36", 32'd36, 32'h1234ABCD, 1'b1, 3'd2, 1'b0);
    cyc("h36", 32'd36, 32'h5678EFDA, 1'b1, 3'd1, 1'b0);
    check("h36_val", 32'h1234EFDA);
    cyc("len5", 32'd36, 32'hFFFFFFFF, 1'b1, 3'd5, 1'b0);
    check("len5_val", 32'h1234EFDA);
    cyc("rst36", 32'd36, 32'hDEADBEEF, 1'b1, 3'd2, 1'b1);
`ifdef MEMORY_RESET_CLEAR_EN
    check("rst36_val", 32'h0);
`else
    check("rst36_val", 32'h1234EFDA);
`endif
    cyc("wrap", D - 2, 32'hCAFEF00D, 1'b1, 3'd2, 1'b0);
    check("wrap_val", 32'hCAFEF00D);
    peek("wrap0", 32'd0);
    tests++;
    assert (read_data[15:0] === 16'hCAFE) else begin
      fails++;
      $error("FAIL wrap0_low: read_data[15:0]=%h expected=%h", read_data[15:0], 16'hCAFE);
    end
    peek("alias", 32'h0001_0000 + D - 2);
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      a = $urandom_range(1) ? $urandom : $urandom_range(D + 7, 0);
      cyc("rnd", a, $urandom, $urandom_range(3) != 0, 3'($urandom_range(7)),
          $urandom_range(15) == 0);
      peek("rnd_peek", $urandom);
    end
    @(negedge clk);
    wr_enable = 1'b0; reset = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
